// File: rtl/vc_sched_pkg.sv
// Shared types and width helpers for the VC packet scheduler.
// The optional credit-overflow check is controlled by VC_SCHED_CREDIT_CHECK_EN (see the top module).
package vc_sched_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } sched_state_t;

    // Field layout of the returned flow-control bus: valid bit, then the VC index above it.
    localparam int FC_VALID_BIT = 0;
    localparam int FC_VC_LSB    = 1;

    function automatic int vc_idx_w(input int numVcs);
        return (numVcs > 1) ? $clog2(numVcs) : 1;
    endfunction

    function automatic int credit_cnt_w(input int bufferSize, input int numVcs);
        return $clog2(bufferSize / numVcs + 1);
    endfunction

    function automatic int len_w(input int minLen, input int maxLen);
        return (maxLen - minLen + 1 > 1) ? $clog2(maxLen - minLen + 1) : 1;
    endfunction

    // Remaining-flit counter must hold 1 + maxLen (head plus payload).
    function automatic int rem_w(input int maxLen);
        return $clog2(maxLen + 2);
    endfunction

endpackage

// File: rtl/vc_credit_counter.sv
// Per-VC downstream credit counter; resets full, counts issues down and returns up.
// With i_full_check high a return to a full counter saturates and flags o_overflow.
module vc_credit_counter #(
    parameter int credit_max = 8,
    parameter int cnt_width  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_inc,
    input  logic i_dec,
    input  logic i_full_check,
    output logic o_nonzero,
    output logic o_overflow
);

    logic [cnt_width-1:0] r_count;
    logic                 w_at_full;

    assign w_at_full  = (r_count == cnt_width'(credit_max));
    assign o_overflow = i_inc & ~i_dec & i_full_check & w_at_full;
    assign o_nonzero  = |r_count;

    // A simultaneous issue and return cancel out; an unchecked overflow simply wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= cnt_width'(credit_max);
        end else if (i_inc && !i_dec && !o_overflow) begin
            r_count <= r_count + cnt_width'(1);
        end else if (i_dec && !i_inc) begin
            r_count <= r_count - cnt_width'(1);
        end
    end

endmodule

// File: rtl/vc_packet_scheduler.sv
// Injection-side scheduler: round-robin VC selection, credit tracking and head/body/tail flit sequencing.
// Define VC_SCHED_CREDIT_CHECK_EN to saturate credit counters and raise a sticky credit_error on overflow.
module vc_packet_scheduler
    import vc_sched_pkg::*;
#(
    parameter  int num_vcs            = 8,
    parameter  int buffer_size        = 64,
    parameter  int min_payload_length = 1,
    parameter  int max_payload_length = 4,
    localparam int vc_idx_width       = vc_idx_w(num_vcs),
    localparam int len_width          = len_w(min_payload_length, max_payload_length)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [num_vcs-1:0]            req_ivc,
    input  logic [num_vcs*len_width-1:0]  req_len_ivc,
    input  logic                          stall,
    input  logic [vc_idx_width:0]         flow_ctrl,
    output logic [num_vcs-1:0]            ack_ivc,
    output logic                          flit_valid,
    output logic                          flit_head,
    output logic                          flit_tail,
    output logic [vc_idx_width-1:0]       flit_vc,
    output logic                          credit_error
);

    localparam int creditMax = buffer_size / num_vcs;
    localparam int cntWidth  = credit_cnt_w(buffer_size, num_vcs);
    localparam int remWidth  = rem_w(max_payload_length);

`ifdef VC_SCHED_CREDIT_CHECK_EN
    localparam logic fullCheck = 1'b1;
`else
    localparam logic fullCheck = 1'b0;
`endif

    sched_state_t              r_state;
    sched_state_t              w_next_state;
    logic [vc_idx_width-1:0]   r_rr_ptr;
    logic [vc_idx_width-1:0]   r_cur_vc;
    logic [remWidth-1:0]       r_remaining;
    logic                      r_first;

    logic [num_vcs-1:0]        r_ack;
    logic                      r_flit_valid;
    logic                      r_flit_head;
    logic                      r_flit_tail;
    logic [vc_idx_width-1:0]   r_flit_vc;
    logic                      r_credit_error;

    logic [num_vcs-1:0]        w_inc;
    logic [num_vcs-1:0]        w_dec;
    logic [num_vcs-1:0]        w_nonzero;
    logic [num_vcs-1:0]        w_overflow;
    logic [num_vcs-1:0]        w_eligible;
    logic [len_width-1:0]      w_len_arr [num_vcs];
    logic [len_width-1:0]      w_pick_len;
    logic [vc_idx_width-1:0]   w_pick;
    logic                      w_found;
    logic                      w_select;
    logic                      w_issue;
    logic                      w_last;

    for (genvar v = 0; v < num_vcs; v++) begin : g_vc
        assign w_inc[v]      = flow_ctrl[FC_VALID_BIT]
                               && (flow_ctrl[vc_idx_width:FC_VC_LSB] == vc_idx_width'(v));
        assign w_dec[v]      = w_issue && (r_cur_vc == vc_idx_width'(v));
        assign w_eligible[v] = req_ivc[v] & w_nonzero[v];
        assign w_len_arr[v]  = req_len_ivc[v*len_width +: len_width];

        vc_credit_counter #(
            .credit_max (creditMax),
            .cnt_width  (cntWidth)
        ) u_credit (
            .clk          (clk),
            .reset        (reset),
            .i_inc        (w_inc[v]),
            .i_dec        (w_dec[v]),
            .i_full_check (fullCheck),
            .o_nonzero    (w_nonzero[v]),
            .o_overflow   (w_overflow[v])
        );
    end

    // Round-robin search: first eligible VC at or after r_rr_ptr, wrapping.
    always_comb begin
        int                      idx;
        logic [vc_idx_width-1:0] cand;
        w_found = 1'b0;
        w_pick  = '0;
        idx     = 0;
        cand    = '0;
        for (int i = 0; i < num_vcs; i++) begin
            idx = int'(r_rr_ptr) + i;
            if (idx >= num_vcs) begin
                idx = idx - num_vcs;
            end
            cand = vc_idx_width'(idx);
            if (!w_found && w_eligible[cand]) begin
                w_found = 1'b1;
                w_pick  = cand;
            end
        end
    end

    assign w_pick_len = w_len_arr[w_pick];
    assign w_last     = (r_remaining == remWidth'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_select) w_next_state = ST_SEND;
            ST_SEND: if (w_issue && w_last) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_select = 1'b0;
        w_issue  = 1'b0;
        if (r_state == ST_IDLE) begin
            w_select = !stall && w_found;
        end else begin
            w_issue = !stall && w_nonzero[r_cur_vc];
        end
    end

    // Packet context is latched once at selection; later length changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cur_vc    <= '0;
            r_remaining <= '0;
            r_first     <= 1'b0;
            r_rr_ptr    <= '0;
        end else begin
            if (w_select) begin
                r_cur_vc    <= w_pick;
                r_remaining <= remWidth'(1 + min_payload_length) + remWidth'(w_pick_len);
                r_first     <= 1'b1;
            end
            if (w_issue) begin
                r_remaining <= r_remaining - remWidth'(1);
                r_first     <= 1'b0;
                if (w_last) begin
                    r_rr_ptr <= (r_cur_vc == vc_idx_width'(num_vcs - 1)) ? '0
                                                                       : r_cur_vc + vc_idx_width'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flit_valid   <= 1'b0;
            r_flit_head    <= 1'b0;
            r_flit_tail    <= 1'b0;
            r_flit_vc      <= '0;
            r_ack          <= '0;
            r_credit_error <= 1'b0;
        end else begin
            r_flit_valid   <= w_issue;
            r_flit_head    <= w_issue & r_first;
            r_flit_tail    <= w_issue & w_last;
            r_ack          <= (w_issue && w_last) ? (num_vcs'(1) << r_cur_vc) : '0;
            r_credit_error <= r_credit_error | (|w_overflow);
            if (w_issue) begin
                r_flit_vc <= r_cur_vc;
            end
        end
    end

    assign flit_valid   = r_flit_valid;
    assign flit_head    = r_flit_head;
    assign flit_tail    = r_flit_tail;
    assign flit_vc      = r_flit_vc;
    assign ack_ivc      = r_ack;
    assign credit_error = r_credit_error;

endmodule

// File: tb/tb_vc_packet_scheduler.sv
// Scoreboard bench for vc_packet_scheduler: a transaction-level model predicts each flit and its cycle,
// a monitor compares the DUT flit stream and credit_error against those predictions.
module tb_vc_packet_scheduler;

    localparam int NV   = 8;
    localparam int BUF  = 64;
    localparam int MINP = 1;
    localparam int MAXP = 4;
    localparam int VW   = 3;
    localparam int LW   = 2;
    localparam int CMAX = BUF / NV;
    localparam int CMOD = 16;
`ifdef VC_SCHED_CREDIT_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic [NV-1:0]     req;
    logic [NV*LW-1:0]  reqLenBus;
    logic              stallIn;
    logic              fcValid;
    logic [VW-1:0]     fcVc;
    logic [NV-1:0]     ack_ivc;
    logic              flit_valid;
    logic              flit_head;
    logic              flit_tail;
    logic [VW-1:0]     flit_vc;
    logic              credit_error;

    int lenCode [NV];

    vc_packet_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .req_ivc      (req),
        .req_len_ivc  (reqLenBus),
        .stall        (stallIn),
        .flow_ctrl    ({fcVc, fcValid}),
        .ack_ivc      (ack_ivc),
        .flit_valid   (flit_valid),
        .flit_head    (flit_head),
        .flit_tail    (flit_tail),
        .flit_vc      (flit_vc),
        .credit_error (credit_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        reqLenBus = '0;
        for (int v = 0; v < NV; v++) begin
            reqLenBus[v*LW +: LW] = LW'(lenCode[v]);
        end
    end

    typedef struct {
        int cyc;
        bit head;
        bit tail;
        int vc;
    } flit_t;

    flit_t expQ[$];
    bit    expErr[int];
    int    cyc = 0;
    int    numChecks = 0;
    int    numFails = 0;

    // Reference model: one outstanding packet, a credit array and a round-robin start point.
    bit mBusy;
    bit mFirst;
    int mCur;
    int mRem;
    int mRr;
    int mCred [NV];
    bit mErr;
    int lastAck;

    task automatic checkOutput(input string name, input int actual, input int expected);
        numChecks++;
        if (actual != expected) begin
            numFails++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    task automatic modelEdge();
        int issuedVc;
        issuedVc = -1;
        lastAck  = -1;
        if (!mBusy) begin
            if (!stallIn) begin
                for (int i = 0; i < NV; i++) begin
                    int v;
                    v = (mRr + i) % NV;
                    if (req[v] && mCred[v] > 0) begin
                        mBusy  = 1'b1;
                        mCur   = v;
                        mRem   = 1 + MINP + lenCode[v];
                        mFirst = 1'b1;
                        break;
                    end
                end
            end
        end else if (!stallIn && mCred[mCur] > 0) begin
            flit_t f;
            f.cyc  = cyc + 1;
            f.head = mFirst;
            f.tail = (mRem == 1);
            f.vc   = mCur;
            expQ.push_back(f);
            issuedVc = mCur;
            mFirst   = 1'b0;
            mRem--;
            if (mRem == 0) begin
                mBusy   = 1'b0;
                mRr     = (mCur + 1) % NV;
                lastAck = mCur;
            end
        end
        if (issuedVc >= 0) mCred[issuedVc]--;
        if (fcValid) begin
            if (int'(fcVc) == issuedVc) mCred[fcVc]++;
            else if (CHECK && mCred[fcVc] == CMAX) mErr = 1'b1;
            else mCred[fcVc] = (mCred[fcVc] + 1) % CMOD;
        end
        expErr[cyc + 1] = mErr;
    endtask

    // One cycle: model the coming edge with the inputs now applied, then act as requester on acks.
    task automatic applyStimulus();
        modelEdge();
        @(negedge clk);
        if (lastAck >= 0) req[lastAck] = 1'b0;
    endtask

    task automatic doReset();
        reset   = 1'b1;
        req     = '0;
        stallIn = 1'b0;
        fcValid = 1'b0;
        fcVc    = '0;
        #1;
        checkOutput("rst_flit_valid", int'(flit_valid), 0);
        checkOutput("rst_flit_head", int'(flit_head), 0);
        checkOutput("rst_flit_tail", int'(flit_tail), 0);
        checkOutput("rst_flit_vc", int'(flit_vc), 0);
        checkOutput("rst_ack", int'(ack_ivc), 0);
        checkOutput("rst_credit_error", int'(credit_error), 0);
        mBusy  = 1'b0;
        mFirst = 1'b0;
        mRr    = 0;
        mErr   = 1'b0;
        for (int v = 0; v < NV; v++) mCred[v] = CMAX;
        expQ.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (flit_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_flit", int'(flit_valid), 0);
                end else begin
                    flit_t e;
                    e = expQ.pop_front();
                    checkOutput("flit_cycle", cyc, e.cyc);
                    checkOutput("flit_head", int'(flit_head), int'(e.head));
                    checkOutput("flit_tail", int'(flit_tail), int'(e.tail));
                    checkOutput("flit_vc", int'(flit_vc), e.vc);
                    checkOutput("ack_ivc", int'(ack_ivc), e.tail ? (1 << e.vc) : 0);
                end
            end else begin
                if (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
                    checkOutput("missing_flit", int'(flit_valid), 1);
                    void'(expQ.pop_front());
                end
                checkOutput("idle_ack", int'(ack_ivc), 0);
            end
            if (!reset && expErr.exists(cyc)) begin
                checkOutput("credit_error", int'(credit_error), int'(expErr[cyc]));
            end
        end
    end

    initial begin
        reset   = 1'b1;
        req     = '0;
        stallIn = 1'b0;
        fcValid = 1'b0;
        fcVc    = '0;
        for (int v = 0; v < NV; v++) lenCode[v] = 0;
        @(negedge clk);
        doReset();

        $display("[TB] single packet on VC2");
        req[2] = 1'b1;
        lenCode[2] = 3;
        repeat (10) applyStimulus();

        $display("[TB] round robin across VCs 0, 3, 7");
        doReset();
        for (int c = 0; c < 20; c++) begin
            req[0] = 1'b1; req[3] = 1'b1; req[7] = 1'b1;
            lenCode[0] = 0; lenCode[3] = 0; lenCode[7] = 0;
            applyStimulus();
        end
        req = '0;
        repeat (3) applyStimulus();

        $display("[TB] credit starvation on VC1");
        doReset();
        lenCode[1] = 3;
        for (int c = 0; c < 16; c++) begin
            req[1] = 1'b1;
            applyStimulus();
        end
        fcValid = 1'b1; fcVc = 3'd1;
        applyStimulus();
        fcValid = 1'b0;
        repeat (4) applyStimulus();
        fcValid = 1'b1; fcVc = 3'd1;
        applyStimulus();
        fcValid = 1'b0;
        repeat (4) applyStimulus();

        $display("[TB] simultaneous issue and return on VC4");
        doReset();
        req[4] = 1'b1;
        lenCode[4] = 3;
        for (int c = 0; c < 8; c++) begin
            fcValid = mBusy && mCur == 4 && mCred[4] > 0;
            fcVc    = 3'd4;
            applyStimulus();
        end
        fcValid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            req[4] = 1'b1;
            applyStimulus();
        end

        $display("[TB] credit return to a full VC0");
        doReset();
        fcValid = 1'b1; fcVc = 3'd0;
        applyStimulus();
        fcValid = 1'b0;
        lenCode[0] = 3;
        for (int c = 0; c < 20; c++) begin
            req[0] = 1'b1;
            applyStimulus();
        end

        $display("[TB] stall mid-packet on VC5");
        doReset();
        req[5] = 1'b1;
        lenCode[5] = 3;
        for (int c = 0; c < 10 && !(mBusy && mRem == 3); c++) applyStimulus();
        stallIn = 1'b1;
        repeat (3) applyStimulus();
        stallIn = 1'b0;
        repeat (6) applyStimulus();

        $display("[TB] reset mid-packet on VC6");
        req[6] = 1'b1;
        lenCode[6] = 3;
        for (int c = 0; c < 10 && !(mBusy && mCur == 6 && mRem == 3); c++) applyStimulus();
        doReset();
        repeat (6) applyStimulus();

        $display("[TB] randomized traffic");
        for (int c = 0; c < 600; c++) begin
            for (int v = 0; v < NV; v++) begin
                if (!req[v] && $urandom_range(0, 99) < 30) req[v] = 1'b1;
                lenCode[v] = $urandom_range(0, 3);
            end
            if (mBusy && $urandom_range(0, 99) < 5) req[mCur] = 1'b0;
            stallIn = ($urandom_range(0, 99) < 15);
            fcValid = 1'b0;
            if ($urandom_range(0, 99) < 45) begin
                int v;
                v = $urandom_range(0, NV - 1);
                if (mCred[v] < CMAX || $urandom_range(0, 19) == 0) begin
                    fcValid = 1'b1;
                    fcVc    = VW'(v);
                end
            end
            applyStimulus();
        end

        req     = '0;
        stallIn = 1'b0;
        fcValid = 1'b0;
        repeat (12) applyStimulus();
        checkOutput("queue_drained", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
